xrisc_store_monitor: RTL and testbench

Synthesisable store-trace monitor and pass/fail detector for the X-RISC single-cycle core, sitting beside `top` on its data-memory write port (`MemWrite`, `DataAdr`, `WriteData`). It records every store into a circular trace buffer for later readout. It flags completion when the program writes the to-host signature address, and raises a timeout if no signature arrives. It generalises the fixed ten-cycle, print-only bench harness into a parametrised, self-checking block usable in simulation and on FPGA.

---
 rtl/xrisc_store_monitor.sv | 127 ++++++++++++
 tb/tb_xrisc_store_monitor.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/xrisc_store_monitor.sv
// rtl/xrisc_store_monitor.sv - store-trace monitor and pass/fail/timeout detector for the X-RISC core
// Trace buffer is built only when XRISC_MON_TRACE_EN is defined.
module xrisc_store_monitor #(
  parameter int              XLEN        = 32,
  parameter int              DEPTH       = 16,
  parameter logic [XLEN-1:0] TOHOST_ADDR = XLEN'(100),
  parameter logic [XLEN-1:0] PASS_VALUE  = XLEN'(25),
  parameter int              TIMEOUT     = 1024
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     mem_write,
  input  logic [XLEN-1:0]          data_adr,
  input  logic [XLEN-1:0]          write_data,
  input  logic                     rd_en,
  output logic                     rd_valid,
  output logic [XLEN-1:0]          rd_adr,
  output logic [XLEN-1:0]          rd_data,
  output logic [$clog2(DEPTH):0]   trace_count,
  output logic                     overflow,
  output logic                     done,
  output logic                     pass,
  output logic                     timeout,
  output logic [31:0]              cycle_count
);

  localparam int          AW       = $clog2(DEPTH);
  localparam int          CW       = AW + 1;
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_RUN, S_PASS, S_FAIL, S_TMO} state_t;

  state_t state, state_nx;
  logic   in_run;
  logic   sig_store;

  assign in_run    = (state == S_RUN);
  assign sig_store = mem_write && (data_adr == TOHOST_ADDR);

  always_ff @(posedge clk) begin
    if (!reset) state <= S_RUN;
    else        state <= state_nx;
  end

  // A signature store on the last allowed cycle takes priority over timeout.
  always_comb begin
    state_nx = state;
    if (state == S_RUN) begin
      if (sig_store)
        state_nx = (write_data == PASS_VALUE) ? S_PASS : S_FAIL;
      else if (cycle_count == TMO_LAST)
        state_nx = S_TMO;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      done        <= 1'b0;
      pass        <= 1'b0;
      timeout     <= 1'b0;
      cycle_count <= 32'd0;
    end else begin
      done    <= (state_nx != S_RUN);
      pass    <= (state_nx == S_PASS);
      timeout <= (state_nx == S_TMO);
      if (in_run && (cycle_count != 32'hFFFF_FFFF))
        cycle_count <= cycle_count + 32'd1;
    end
  end

`ifdef XRISC_MON_TRACE_EN
  logic [XLEN-1:0] mem_adr [DEPTH];
  logic [XLEN-1:0] mem_dat [DEPTH];
  logic [AW-1:0]   wptr, rptr;
  logic            push, pop, full;

  assign push = in_run && mem_write;
  assign pop  = rd_en && (trace_count != '0);
  assign full = (trace_count == CW'(DEPTH));

  always_ff @(posedge clk) begin
    if (push) begin
      mem_adr[wptr] <= data_adr;
      mem_dat[wptr] <= write_data;
    end
  end

  // When full, a lone push lands on the oldest slot, so the read pointer moves with it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wptr        <= '0;
      rptr        <= '0;
      trace_count <= '0;
      overflow    <= 1'b0;
      rd_valid    <= 1'b0;
      rd_adr      <= '0;
      rd_data     <= '0;
    end else begin
      rd_valid <= pop;
      if (pop) begin
        rd_adr  <= mem_adr[rptr];
        rd_data <= mem_dat[rptr];
      end
      if (push)
        wptr <= wptr + AW'(1);
      if (pop || (push && full))
        rptr <= rptr + AW'(1);
      if (push && full && !pop)
        overflow <= 1'b1;
      if (push && !pop && !full)
        trace_count <= trace_count + CW'(1);
      else if (pop && !push)
        trace_count <= trace_count - CW'(1);
    end
  end
`else
  logic unused_rd_en;

  assign unused_rd_en = rd_en;
  assign rd_valid     = 1'b0;
  assign rd_adr       = '0;
  assign rd_data      = '0;
  assign trace_count  = '0;
  assign overflow     = 1'b0;
`endif

endmodule

// File: tb/tb_xrisc_store_monitor.sv
// tb/tb_xrisc_store_monitor.sv - directed scoreboard bench for xrisc_store_monitor
module tb_xrisc_store_monitor;

`ifdef XRISC_MON_TRACE_EN
  localparam bit TR = 1'b1;
`else
  localparam bit TR = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b0, mem_write = 1'b0, rd_en = 1'b0;
  logic [31:0] data_adr = '0, write_data = '0;
  logic        rd_valid, overflow, done, pass, timeout;
  logic [31:0] rd_adr, rd_data, cycle_count;
  logic [2:0]  trace_count;

  logic        t_reset = 1'b0, t_mem_write = 1'b0, t_rd_en = 1'b0;
  logic [31:0] t_adr = '0, t_data = '0;
  logic        t_rd_valid, t_overflow, t_done, t_pass, t_timeout;
  logic [31:0] t_rd_adr, t_rd_data, t_cycle_count;
  logic [2:0]  t_trace_count;

  xrisc_store_monitor #(.DEPTH(4), .TIMEOUT(32)) dut (
    .clk(clk), .reset(reset), .mem_write(mem_write), .data_adr(data_adr),
    .write_data(write_data), .rd_en(rd_en), .rd_valid(rd_valid), .rd_adr(rd_adr),
    .rd_data(rd_data), .trace_count(trace_count), .overflow(overflow), .done(done),
    .pass(pass), .timeout(timeout), .cycle_count(cycle_count)
  );

  xrisc_store_monitor #(.DEPTH(4), .TIMEOUT(8)) dut_t (
    .clk(clk), .reset(t_reset), .mem_write(t_mem_write), .data_adr(t_adr),
    .write_data(t_data), .rd_en(t_rd_en), .rd_valid(t_rd_valid), .rd_adr(t_rd_adr),
    .rd_data(t_rd_data), .trace_count(t_trace_count), .overflow(t_overflow), .done(t_done),
    .pass(t_pass), .timeout(t_timeout), .cycle_count(t_cycle_count)
  );

  typedef struct {logic [31:0] a; logic [31:0] d;} ent_t;
  ent_t q[$];
  bit   ovf_m;
  bit   run_m;
  int   total = 0;
  int   bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".rd_valid"}, 32'(rd_valid), 32'd0);
    chk({tag, ".rd_adr"}, rd_adr, 32'd0);
    chk({tag, ".rd_data"}, rd_data, 32'd0);
    chk({tag, ".count"}, 32'(trace_count), 32'd0);
    chk({tag, ".overflow"}, 32'(overflow), 32'd0);
    chk({tag, ".done"}, 32'(done), 32'd0);
    chk({tag, ".pass"}, 32'(pass), 32'd0);
    chk({tag, ".timeout"}, 32'(timeout), 32'd0);
    chk({tag, ".cycles"}, cycle_count, 32'd0);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b0; mem_write = 1'b0; rd_en = 1'b0;
    tick();
    tick();
    chk_all_zero(tag);
    reset = 1'b1;
    q.delete();
    ovf_m = 1'b0;
    run_m = 1'b1;
  endtask

  // Model first, then drive one edge; expected pops come off the scoreboard queue.
  task automatic step(input bit we, input logic [31:0] a, input logic [31:0] d,
                      input bit re, input string tag);
    ent_t e;
    bit   popping;
    bit   exp_v;
    e = '{32'd0, 32'd0};
    popping = re && (q.size() > 0);
    if (popping) e = q.pop_front();
    if (we && run_m) begin
      if (q.size() == 4) begin
        q.delete(0);
        ovf_m = 1'b1;
      end
      q.push_back('{a, d});
      if (a == 32'd100) run_m = 1'b0;
    end
    mem_write = we; data_adr = a; write_data = d; rd_en = re;
    tick();
    mem_write = 1'b0; rd_en = 1'b0;
    exp_v = TR && popping;
    chk({tag, ".rd_valid"}, 32'(rd_valid), 32'(exp_v));
    if (exp_v) begin
      chk({tag, ".rd_adr"}, rd_adr, e.a);
      chk({tag, ".rd_data"}, rd_data, e.d);
    end
    chk({tag, ".count"}, 32'(trace_count), TR ? 32'(q.size()) : 32'd0);
    chk({tag, ".overflow"}, 32'(overflow), 32'(TR && ovf_m));
  endtask

  initial begin
    // pass run
    do_reset("rst1");
    step(1'b1, 32'd80, 32'd7, 1'b0, "s1_st0");
    chk("s1_done_early", 32'(done), 32'd0);
    step(1'b1, 32'd84, 32'hFFFF_FFFC, 1'b0, "s1_st1");
    step(1'b1, 32'd100, 32'd25, 1'b0, "s1_st2");
    chk("s1_done", 32'(done), 32'd1);
    chk("s1_pass", 32'(pass), 32'd1);
    chk("s1_timeout", 32'(timeout), 32'd0);
    chk("s1_cycles", cycle_count, 32'd3);
    for (int i = 0; i < 3; i++) step(1'b0, 32'd0, 32'd0, 1'b1, "s1_pop");
    step(1'b0, 32'd0, 32'd0, 1'b1, "s1_pop_empty");
    chk("s1_cycles_frozen", cycle_count, 32'd3);

    // fail run, no capture afterwards
    do_reset("rst2");
    step(1'b1, 32'd100, 32'd24, 1'b0, "s2_sig");
    chk("s2_done", 32'(done), 32'd1);
    chk("s2_pass", 32'(pass), 32'd0);
    chk("s2_timeout", 32'(timeout), 32'd0);
    step(1'b1, 32'd40, 32'd5, 1'b0, "s2_late");

    // overflow, readout, simultaneous push/pop, reset mid-readout
    do_reset("rst3");
    for (int i = 1; i <= 6; i++) step(1'b1, 32'(4 * i), 32'(i), 1'b0, "s4_st");
    for (int i = 0; i < 4; i++) step(1'b0, 32'd0, 32'd0, 1'b1, "s4_pop");
    step(1'b0, 32'd0, 32'd0, 1'b1, "s4_pop_empty");
    for (int i = 0; i < 4; i++) step(1'b1, 32'(200 + 4 * i), 32'(10 + i), 1'b0, "s5_fill");
    step(1'b1, 32'd300, 32'd9, 1'b1, "s5_pushpop");
    step(1'b0, 32'd0, 32'd0, 1'b1, "s5_pop");
    chk("s5_done", 32'(done), 32'd0);
    reset = 1'b0; rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk_all_zero("s5_rst");
    reset = 1'b1;

    // timeout at TIMEOUT=8
    t_reset = 1'b0; tick(); tick(); t_reset = 1'b1;
    repeat (7) tick();
    chk("t_timeout_early", 32'(t_timeout), 32'd0);
    chk("t_done_early", 32'(t_done), 32'd0);
    chk("t_cycles7", t_cycle_count, 32'd7);
    tick();
    chk("t_timeout", 32'(t_timeout), 32'd1);
    chk("t_done", 32'(t_done), 32'd1);
    chk("t_pass", 32'(t_pass), 32'd0);
    chk("t_cycles8", t_cycle_count, 32'd8);
    repeat (3) tick();
    chk("t_cycles_frozen", t_cycle_count, 32'd8);
    chk("t_timeout_hold", 32'(t_timeout), 32'd1);

    // signature on the last allowed cycle beats timeout
    t_reset = 1'b0; tick(); tick(); t_reset = 1'b1;
    repeat (7) tick();
    t_mem_write = 1'b1; t_adr = 32'd100; t_data = 32'd25;
    tick();
    t_mem_write = 1'b0;
    chk("tw_pass", 32'(t_pass), 32'd1);
    chk("tw_timeout", 32'(t_timeout), 32'd0);
    chk("tw_cycles", t_cycle_count, 32'd8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
